// File: rtl/unibus_pkg.sv
// ============================================================================
// Module      : unibus_pkg
// Description : Shared types and helpers for the unidirectional bus family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package unibus_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Next source index with wrap-around.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/unibus_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; searches from ptr+1 upward with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import unibus_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int SRC_W = $clog2(NSRC)
) (
    input  logic [NSRC-1:0]  req,
    input  logic [SRC_W-1:0] ptr,
    input  logic             en,
    output logic [NSRC-1:0]  grant,
    output logic [SRC_W-1:0] idx
);

    logic             w_found;
    logic [SRC_W-1:0] w_cand;

    always_comb begin
        w_found = 1'b0;
        idx     = '0;
        w_cand  = ptr;
        for (int k = 0; k < NSRC; k++) begin
            w_cand = SRC_W'(next_idx(int'(w_cand), NSRC));
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                idx     = w_cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NSRC; i++) begin
            grant[i] = en && w_found && (int'(idx) == i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/unibus_arbiter.sv
// ============================================================================
// Module      : unibus_arbiter
// Description : N-source round-robin arbitrated bus with one holding register.
//               Optional even parity output enabled by UNIBUS_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unibus_arbiter
    import unibus_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NSRC  = 4,
    localparam int SRC_W = $clog2(NSRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    output logic [NSRC-1:0]         src_ready,
    input  logic                    bus_enable,
    output logic                    bus_valid,
    output logic [WIDTH-1:0]        bus_data,
    output logic [SRC_W-1:0]        bus_src,
    input  logic                    bus_ready
`ifdef UNIBUS_PARITY_EN
    ,
    output logic                    bus_par
`endif
);

    state_e           r_state;
    logic [WIDTH-1:0] r_data;
    logic [SRC_W-1:0] r_src;
    logic [SRC_W-1:0] r_ptr;

    logic             w_pop;
    logic             w_load;
    logic [SRC_W-1:0] w_idx;
    logic [WIDTH-1:0] w_word;

    assign bus_valid = (r_state == ST_FULL);
    assign bus_data  = r_data;
    assign bus_src   = r_src;

    assign w_pop  = bus_valid & bus_ready;
    // rst_n gates the grant so no source sees src_ready while reset is held.
    assign w_load = rst_n & bus_enable & (|src_valid) & (~bus_valid | bus_ready);

    rr_arbiter #(
        .NSRC  (NSRC),
        .SRC_W (SRC_W)
    ) u_arb (
        .req   (src_valid),
        .ptr   (r_ptr),
        .en    (w_load),
        .grant (src_ready),
        .idx   (w_idx)
    );

    assign w_word = src_data[int'(w_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= SRC_W'(NSRC - 1);
        end else if (w_load) begin
            r_state <= ST_FULL;
            r_data  <= w_word;
            r_src   <= w_idx;
            r_ptr   <= w_idx;
        end else if (w_pop) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_src   <= '0;
        end
    end

`ifdef UNIBUS_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^w_word;
        end else if (w_pop) begin
            r_par <= 1'b0;
        end
    end

    assign bus_par = r_par;
`endif

endmodule

`default_nettype wire

// File: tb/tb_unibus_arbiter.sv
// ============================================================================
// Module      : tb_unibus_arbiter
// Description : Scoreboard bench for unibus_arbiter (WIDTH=4, NSRC=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unibus_arbiter;

    localparam int WIDTH = 4;
    localparam int NSRC  = 4;
    localparam int SRC_W = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [SRC_W-1:0] src;
    } entry_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NSRC-1:0]       src_valid = '0;
    logic [NSRC*WIDTH-1:0] src_data = '0;
    logic [NSRC-1:0]       src_ready;
    logic                  bus_enable = 1'b1;
    logic                  bus_valid;
    logic [WIDTH-1:0]      bus_data;
    logic [SRC_W-1:0]      bus_src;
    logic                  bus_ready = 1'b0;
`ifdef UNIBUS_PARITY_EN
    logic                  bus_par;
`endif

    int     tests = 0;
    int     fails = 0;
    entry_t q[$];
    int     mptr = NSRC - 1;

    unibus_arbiter #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .bus_enable (bus_enable),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .bus_src    (bus_src),
        .bus_ready  (bus_ready)
`ifdef UNIBUS_PARITY_EN
        ,
        .bus_par    (bus_par)
`endif
    );

    always #5 clk = ~clk;

    // One clock of stimulus: predict grant, push expected word, compare register.
    task automatic tick();
        logic [NSRC-1:0] er;
        logic            eload;
        int              win;
        int              c;
        entry_t          e;
        #1;
        eload = rst_n && bus_enable && (|src_valid) && (q.size() == 0 || bus_ready);
        win = 0;
        c = mptr;
        for (int k = 0; k < NSRC; k++) begin
            c = (c + 1) % NSRC;
            if (src_valid[c]) begin
                win = c;
                break;
            end
        end
        er = '0;
        if (eload) er[win] = 1'b1;
        tests++;
        if (src_ready !== er) begin
            fails++;
            $display("FAIL sb_src_ready: got %b want %b", src_ready, er);
        end
        if (q.size() > 0 && bus_ready) void'(q.pop_front());
        if (eload) begin
            e.data = src_data[win*WIDTH +: WIDTH];
            e.src  = SRC_W'(win);
            q.push_back(e);
            mptr = win;
        end
        @(posedge clk);
        #1;
        tests++;
        if (q.size() == 0) begin
            if (bus_valid !== 1'b0 || bus_data !== '0 || bus_src !== '0) begin
                fails++;
                $display("FAIL sb_empty: got v=%b d=%h s=%0d want v=0 d=0 s=0",
                         bus_valid, bus_data, bus_src);
            end
        end else begin
            if (bus_valid !== 1'b1 || bus_data !== q[0].data || bus_src !== q[0].src) begin
                fails++;
                $display("FAIL sb_word: got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                         bus_valid, bus_data, bus_src, q[0].data, q[0].src);
            end
        end
`ifdef UNIBUS_PARITY_EN
        tests++;
        if (bus_par !== ((q.size() == 0) ? 1'b0 : ^q[0].data)) begin
            fails++;
            $display("FAIL sb_parity: got %b", bus_par);
        end
`endif
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        mptr = NSRC - 1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        src_valid  = 4'hF;
        src_data   = 16'h4321;
        bus_enable = 1'b1;
        bus_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (bus_valid !== 1'b0 || bus_data !== '0 || bus_src !== '0 || src_ready !== '0) begin
                fails++;
                $display("FAIL reset: got v=%b d=%h s=%0d r=%b want all 0",
                         bus_valid, bus_data, bus_src, src_ready);
            end
        end
        src_valid = '0;
        q.delete();
        mptr  = NSRC - 1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        src_valid = 4'b0100;
        src_data  = '0;
        src_data[2*WIDTH +: WIDTH] = 4'hA;
        bus_ready = 1'b1;
        #1;
        tests++;
        if (src_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_grant: got %b want 0100", src_ready);
        end
        tick();
        tests++;
        if (bus_valid !== 1'b1 || bus_data !== 4'hA || bus_src !== 2'd2) begin
            fails++;
            $display("FAIL single_word: got v=%b d=%h s=%0d want v=1 d=a s=2",
                     bus_valid, bus_data, bus_src);
        end
        src_valid = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [SRC_W-1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        src_valid = 4'hF;
        for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = WIDTH'(i + 8);
        bus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (bus_valid !== 1'b1 || bus_src !== seq[i]) begin
                fails++;
                $display("FAIL fairness[%0d]: got v=%b s=%0d want v=1 s=%0d",
                         i, bus_valid, bus_src, seq[i]);
            end
        end
        src_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        src_valid = 4'b0001;
        src_data  = 16'h9875;
        bus_ready = 1'b0;
        tick();
        src_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (src_ready !== '0) begin
                fails++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", i, src_ready);
            end
            tick();
            tests++;
            if (bus_data !== 4'h5 || bus_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=5", i, bus_valid, bus_data);
            end
        end
        bus_ready = 1'b1;
        tick();
        tests++;
        if (bus_src !== 2'd1 || bus_data !== 4'h7 || bus_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got v=%b d=%h s=%0d want v=1 d=7 s=1",
                     bus_valid, bus_data, bus_src);
        end
        src_valid = '0;
        tick();
    endtask

    task automatic test_enable();
        apply_reset();
        src_valid = 4'b0001;
        src_data  = 16'hCBA3;
        bus_ready = 1'b0;
        tick();
        bus_enable = 1'b0;
        src_valid  = 4'hF;
        tick();
        bus_ready = 1'b1;
        tick();
        tests++;
        if (bus_valid !== 1'b0) begin
            fails++;
            $display("FAIL enable_drain: got v=%b want 0", bus_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (src_ready !== '0 || bus_valid !== 1'b0) begin
                fails++;
                $display("FAIL enable_block[%0d]: got r=%b v=%b want 0", i, src_ready, bus_valid);
            end
        end
        bus_enable = 1'b1;
        tick();
        tests++;
        if (bus_src !== 2'd1 || bus_data !== 4'hA) begin
            fails++;
            $display("FAIL enable_resume: got d=%h s=%0d want d=a s=1", bus_data, bus_src);
        end
        src_valid = '0;
        tick();
    endtask

    task automatic test_parity();
        apply_reset();
        bus_ready = 1'b1;
        src_valid = 4'b0001;
        src_data  = 16'h0007;
        tick();
`ifdef UNIBUS_PARITY_EN
        tests++;
        if (bus_par !== 1'b1) begin
            fails++;
            $display("FAIL parity_7: got %b want 1", bus_par);
        end
`endif
        src_valid = 4'b0010;
        src_data  = 16'h0060;
        tick();
`ifdef UNIBUS_PARITY_EN
        tests++;
        if (bus_par !== 1'b0) begin
            fails++;
            $display("FAIL parity_6: got %b want 0", bus_par);
        end
`endif
        src_valid = '0;
        tick();
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        src_valid = 4'b1000;
        src_data  = 16'hE000;
        bus_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus_valid !== 1'b0 || bus_data !== '0 || bus_src !== '0 || src_ready !== '0) begin
            fails++;
            $display("FAIL reset_mid: got v=%b d=%h s=%0d r=%b want all 0",
                     bus_valid, bus_data, bus_src, src_ready);
        end
`ifdef UNIBUS_PARITY_EN
        tests++;
        if (bus_par !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_par: got %b want 0", bus_par);
        end
`endif
        src_valid = '0;
        @(posedge clk);
        #1;
        q.delete();
        mptr  = NSRC - 1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            src_valid  = NSRC'($urandom_range(0, 15));
            src_data   = (NSRC*WIDTH)'($urandom);
            bus_enable = ($urandom_range(0, 3) != 0);
            bus_ready  = ($urandom_range(0, 2) != 0);
            tick();
        end
        src_valid  = '0;
        bus_enable = 1'b1;
        bus_ready  = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_enable();
        test_parity();
        test_reset_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/unibus_arbiter.md
# unibus_arbiter

Parametrised N-source unidirectional bus: NSRC producers each offer a WIDTH-bit word with valid/ready, a round-robin arbiter grants one per cycle, and the winning word is registered onto a single one-way output bus with its own valid/ready. It is the next generation of the team's enable-gated unidirectional bus: it generalises width and source count and adds arbitration, backpressure and a holding register. It sits between multiple datapath producers and one shared consumer.

## Interface
- WIDTH, 4, data bits per word (≥1)
- NSRC, 4, number of sources (≥2); SRC_W = $clog2(NSRC)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- src_valid  in  NSRC  source i offers a word
- src_data  in  NSRC*WIDTH  source i word at bits [i*WIDTH +: WIDTH]
- src_ready  out  NSRC  one-hot-or-zero; source i word accepted this cycle
- bus_enable  in  1  global enable; 0 blocks new grants
- bus_valid  out  1  output register holds a word
- bus_data  out  WIDTH  held word; 0 when bus_valid=0
- bus_src  out  SRC_W  index of source that supplied bus_data; 0 when bus_valid=0
- bus_ready  in  1  consumer accepts word this cycle
- bus_par  out  1  only with UNIBUS_PARITY_EN (see Configuration)

## Operation
- One output register; two states: EMPTY (bus_valid=0), FULL (bus_valid=1).
- pop = bus_valid & bus_ready.
- load = bus_enable & |src_valid & (!bus_valid | bus_ready).
- Winner: first i with src_valid[i], searching from (ptr+1) mod NSRC upward with wrap.
- src_ready[winner] = load (combinational); all other src_ready = 0.
- On load: register ← {src_data[winner], winner}; ptr ← winner; state FULL.
- On pop without load: register cleared to 0, state EMPTY.
- On pop with load (same cycle): register replaced; bus_valid stays 1 — full throughput, one word/cycle.
- FULL & !bus_ready: bus_data, bus_src stable; no src_ready asserted; ptr unchanged.
- bus_enable=0: no loads; a word already FULL stays presented and drains normally on bus_ready.
- Round-robin fairness: source granted at most once per NSRC consecutive grants while all others are requesting.
- src_data of non-granted sources ignored; src_valid may drop without a grant (no source-side commitment).

## Timing
- Reset (async assert, sync-effect on deassert): bus_valid=0, bus_data=0, bus_src=0, ptr=NSRC-1 (source 0 wins first), bus_par=0.
- Latency: grant cycle n (src_ready high) → bus_valid/bus_data visible cycle n+1.
- src_ready depends combinationally on src_valid, bus_valid, bus_ready, bus_enable; no combinational path from src_data to any output.
- Reset mid-transfer: held word discarded immediately; no src_ready during rst_n=0.

## Configuration
- UNIBUS_PARITY_EN defined: port bus_par present, registered with the data, equal to ^bus_data (even parity; 0 when EMPTY).
- Not defined: bus_par port and its flop absent; all other behaviour identical.

## Structure
- Package unibus_pkg: state enum (EMPTY, FULL) and a next-index-with-wrap function shared with sibling bus blocks.
- Sub-module rr_arbiter (params NSRC): inputs req, ptr, en; outputs one-hot grant and encoded index. Top holds register, ptr, handshake.

## Test plan
- Reset: drive src_valid=4'hF, rst_n=0 → bus_valid=0, bus_data=0, bus_src=0, src_ready=0 throughout.
- Single source: src_valid=4'b0100, src_data[2]=4'hA, bus_ready=1 → src_ready=4'b0100 cycle n; bus_valid=1, bus_data=4'hA, bus_src=2 cycle n+1.
- Fairness: all four valid, bus_ready=1 constantly → bus_src sequence 0,1,2,3,0,1 with bus_valid never dropping.
- Backpressure: FULL with bus_data=4'h5, bus_ready=0 for 3 cycles → bus_data stays 4'h5, src_ready=0; bus_ready=1 → next winner loads same cycle.
- Enable: bus_enable=0 with src_valid=4'hF and FULL word 4'h3 → 4'h3 drains on bus_ready, bus_valid then 0, no src_ready until bus_enable=1.
- Parity (UNIBUS_PARITY_EN): words 4'h7, 4'h6 → bus_par 1, 0; async reset mid-FULL → all outputs 0 within same cycle.
